// File: rtl/imem_fetch_ctrl_pkg.sv
// imem_fetch_ctrl_pkg: shared widths and the fetch FSM state type.
package imem_fetch_ctrl_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int INSTR_W_DEF = 16;
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
endpackage

// File: rtl/imem_fetch_ctrl_queue.sv
// imem_fetch_ctrl_queue: small prefetch FIFO holding {instr,pc} entries with flush.
module imem_fetch_ctrl_queue #(
  parameter int W = 48,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd, wr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wr] <= din;
        wr <= wr + 1'b1;
      end
      if (pop) rd <= rd + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  assign head = mem[rd];
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && !flush && count == CW'(DEPTH)));
endmodule

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: PC owner and fetch sequencer feeding decode through a prefetch queue.
// Redirects flush the queue and toggle an epoch so a fetch already in flight is dropped.
module imem_fetch_ctrl
  import imem_fetch_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int QDEPTH = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic               inst_valid,
  output logic [INSTR_W-1:0] inst_out,
  output logic [ADDR_W-1:0]  inst_pc,
  input  logic               inst_ready,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               halt_req,
  input  logic               resume,
  output logic               halted
);
  localparam int CW = $clog2(QDEPTH) + 1;
  state_t              state;
  logic [ADDR_W-1:0]   pc, tag_addr;
  logic                inflight, epoch, tag_epoch;
  logic [CW-1:0]       count;
  logic                issue, push, pop;
  logic [INSTR_W+ADDR_W-1:0] head;
  assign pop = inst_valid && inst_ready;
  // Credit counts the slot freed by this cycle's pop so a ready consumer sees one instruction per cycle.
  assign issue = state == RUN && !halt_req && (count - CW'(pop) + CW'(inflight)) < CW'(QDEPTH);
  assign push = inflight && tag_epoch == epoch && !redirect_valid;
  assign inst_valid = count != '0;
  assign imem_addr = pc;
  assign {inst_out, inst_pc} = head;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc <= RESET_PC;
      inflight <= 1'b0;
      tag_addr <= '0;
      tag_epoch <= 1'b0;
      epoch <= 1'b0;
      state <= RUN;
      halted <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        tag_addr <= pc;
        tag_epoch <= epoch;
      end
      pc <= redirect_valid ? redirect_pc : issue ? pc + 1'b1 : pc;
      if (redirect_valid) epoch <= ~epoch;
      case (state)
        RUN: if (halt_req) state <= DRAIN;
        DRAIN:
          if (!halt_req) state <= RUN;
          else if (!inflight) begin
            state <= HALTED;
            halted <= 1'b1;
          end
        HALTED:
          if (resume && !halt_req) begin
            state <= RUN;
            halted <= 1'b0;
          end
        default: state <= RUN;
      endcase
    end
  imem_fetch_ctrl_queue #(.W(INSTR_W + ADDR_W), .DEPTH(QDEPTH)) u_queue (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .pop(pop),
    .flush(redirect_valid),
    .din({imem_instr, tag_addr}),
    .head(head),
    .count(count)
  );
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb_imem_fetch_ctrl: directed scenarios plus random traffic checked against a program-order model.
module tb_imem_fetch_ctrl;
  logic        clk = 0, rst_n = 0;
  logic [31:0] imem_addr, inst_pc, redirect_pc = '0;
  logic [15:0] imem_instr = '0, inst_out;
  logic        inst_valid, inst_ready = 0, redirect_valid = 0, halt_req = 0, resume = 0, halted;
  int          errors = 0, checks = 0;
  logic [31:0] exp_pc = '0, aq = '0;
  logic        hq = 0, rq = 0;

  imem_fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .inst_valid(inst_valid), .inst_out(inst_out), .inst_pc(inst_pc), .inst_ready(inst_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt_req(halt_req),
    .resume(resume), .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_f(logic [31:0] a);
    return (a[15:0] * 16'h9E37) ^ a[31:16] ^ 16'h5A5A;
  endfunction

  always @(posedge clk) imem_instr <= mem_f(imem_addr);

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Program-order model: every accepted instruction is the next PC of the current stream.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_pc = '0;
      hq = 0;
      rq = 0;
    end else begin
      if (inst_valid && inst_ready) begin
        check("seq_pc", inst_pc, exp_pc);
        check("seq_instr", inst_out, mem_f(inst_pc));
        exp_pc = exp_pc + 1;
      end
      if (halted && hq && !rq) check("halt_addr_hold", imem_addr, aq);
      if (redirect_valid) exp_pc = redirect_pc;
      hq = halted;
      rq = redirect_valid;
      aq = imem_addr;
    end
  end

  task automatic do_reset();
    rst_n = 0;
    redirect_valid = 0;
    halt_req = 0;
    resume = 0;
    repeat (2) tick();
    check("rst_addr", imem_addr, 0);
    check("rst_valid", inst_valid, 0);
    check("rst_halted", halted, 0);
    check("rst_out", inst_out, 0);
    check("rst_pc", inst_pc, 0);
    rst_n = 1;
  endtask

  task automatic expect_next(string tag, logic [31:0] p);
    int n = 0;
    while (!(inst_valid && inst_ready) && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_timeout"}, n >= 20, 0);
    check({tag, "_pc"}, inst_pc, p);
    check({tag, "_instr"}, inst_out, mem_f(p));
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit");
    $fatal(1);
  end

  initial begin
    // back-to-back delivery after reset
    inst_ready = 1;
    do_reset();
    check("c0_valid", inst_valid, 0);
    tick();
    check("c1_valid", inst_valid, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      check("b2b_valid", inst_valid, 1);
      check("b2b_pc", inst_pc, i);
      check("b2b_instr", inst_out, mem_f(i));
      tick();
    end
    // stall fills the queue and freezes the address
    inst_ready = 0;
    do_reset();
    repeat (6) tick();
    check("stall_addr", imem_addr, 2);
    check("stall_valid", inst_valid, 1);
    check("stall_head", inst_pc, 0);
    inst_ready = 1;
    expect_next("stall0", 0);
    expect_next("stall1", 1);
    expect_next("stall2", 2);
    // redirect with a fetch in flight and a queued entry
    inst_ready = 0;
    do_reset();
    repeat (2) tick();
    redirect_valid = 1;
    redirect_pc = 32'h40;
    tick();
    redirect_valid = 0;
    check("redir_flush", inst_valid, 0);
    check("redir_addr", imem_addr, 32'h40);
    inst_ready = 1;
    expect_next("redir0", 32'h40);
    expect_next("redir1", 32'h41);
    // halt with imem_addr at 5
    do_reset();
    repeat (5) tick();
    check("halt_pre_addr", imem_addr, 5);
    halt_req = 1;
    tick();
    check("drain_halted", halted, 0);
    tick();
    check("halted_set", halted, 1);
    repeat (3) tick();
    check("halted_stay", halted, 1);
    check("halted_addr", imem_addr, 5);
    halt_req = 0;
    resume = 1;
    tick();
    resume = 0;
    check("resumed", halted, 0);
    expect_next("resume0", 5);
    expect_next("resume1", 6);
    // PC wrap
    redirect_valid = 1;
    redirect_pc = 32'hFFFF_FFFF;
    tick();
    redirect_valid = 0;
    expect_next("wrap0", 32'hFFFF_FFFF);
    expect_next("wrap1", 32'h0);
    // async reset with a full queue
    inst_ready = 0;
    do_reset();
    repeat (4) tick();
    check("full_valid", inst_valid, 1);
    rst_n = 0;
    #1;
    check("async_valid", inst_valid, 0);
    check("async_addr", imem_addr, 0);
    tick();
    rst_n = 1;
    inst_ready = 1;
    expect_next("restart", 0);
    // random traffic
    for (int c = 0; c < 600; c++) begin
      inst_ready = $urandom_range(0, 9) < 7;
      redirect_valid = $urandom_range(0, 24) == 0;
      redirect_pc = $urandom_range(0, 3) == 0 ? 32'hFFFF_FFFE : $urandom;
      if ($urandom_range(0, 29) == 0) halt_req = ~halt_req;
      resume = $urandom_range(0, 7) == 0;
      tick();
    end
    redirect_valid = 0;
    halt_req = 0;
    inst_ready = 1;
    resume = 1;
    tick();
    resume = 0;
    begin
      int n = 0;
      while (!inst_valid && n < 20) begin
        tick();
        n++;
      end
      check("final_live", inst_valid, 1);
    end
    repeat (4) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
